w_mem_loader: RTL and testbench

Weight-memory loader sitting directly upstream of the weight SRAM wrapper. Accepts a byte stream of 8-bit signed weights over a valid/ready handshake, packs four bytes into one 32-bit row word, and issues sequential writes on either the CNN write port or the FC write port of the weight memory. A start/done command interface, driven by the control unit or DMA, frames each transfer: base address, word count, target port.

---
 rtl/w_mem_loader_pkg.sv | 19 +
 rtl/w_mem_byte_packer.sv | 64 ++++++
 rtl/w_mem_loader.sv | 148 ++++++++++++++
 tb/tb_w_mem_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w_mem_loader_pkg.sv
// Shared constants and FSM state type for the weight-memory loader.
package w_mem_loader_pkg;

   localparam int N_DIM_ARRAY             = 4;
   localparam int WEIGHT_DATA_WIDTH       = 8;
   localparam int WEIGHT_MEMORY_ADDR_SIZE = 14;
   localparam int CNT_WIDTH               = 15;

   // Port select encoding for cfg_fc.
   localparam logic MODE_CNN = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/w_mem_byte_packer.sv
// Lane counter, shift-in register and one-word output register with its
// valid/stall handshake. The first byte of a word lands in the top lane.
module w_mem_byte_packer
   import w_mem_loader_pkg::*;
#(
   parameter int LANES  = N_DIM_ARRAY,
   parameter int BYTE_W = WEIGHT_DATA_WIDTH,
   parameter int ADDR_W = WEIGHT_MEMORY_ADDR_SIZE
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    byte_fire_i,
   input  logic [BYTE_W-1:0]       byte_i,
   input  logic [ADDR_W-1:0]       addr_i,
   input  logic                    stall_i,
   output logic                    last_lane_o,
   output logic                    word_load_o,
   output logic                    out_valid_o,
   output logic                    wr_fire_o,
   output logic [LANES*BYTE_W-1:0] out_word_o,
   output logic [ADDR_W-1:0]       out_addr_o
);

   localparam int WORD_W = LANES * BYTE_W;
   localparam int LANE_W = $clog2(LANES);

   logic [LANE_W-1:0]        lane_q;
   logic [WORD_W-BYTE_W-1:0] shift_q;
   logic                     out_valid_q;
   logic [WORD_W-1:0]        out_word_q;
   logic [ADDR_W-1:0]        out_addr_q;

   assign last_lane_o = (lane_q == LANE_W'(LANES - 1));
   assign word_load_o = byte_fire_i && last_lane_o;
   assign wr_fire_o   = out_valid_q && !stall_i;
   assign out_valid_o = out_valid_q;
   assign out_word_o  = out_word_q;
   assign out_addr_o  = out_addr_q;

   // Shift bytes in, hand the completed word to the output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q      <= '0;
         shift_q     <= '0;
         out_valid_q <= 1'b0;
         out_word_q  <= '0;
         out_addr_q  <= '0;
      end else begin
         if (byte_fire_i) begin
            shift_q <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_i};
            lane_q  <= last_lane_o ? '0 : lane_q + 1'b1;
         end
         // A load in the same cycle as a write keeps the register full.
         if (word_load_o) begin
            out_word_q  <= {shift_q, byte_i};
            out_addr_q  <= addr_i;
            out_valid_q <= 1'b1;
         end else if (wr_fire_o) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/w_mem_loader.sv
// Weight-memory loader: packs a byte stream into row words and writes them
// sequentially on the CNN or FC port of the weight memory.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; config latched when it arrives
// LOAD     | accepting bytes, words written as they complete
// DRAIN    | all bytes in, waiting for the last word to be written
// DONE     | one-cycle done pulse, back to IDLE next cycle
module w_mem_loader
   import w_mem_loader_pkg::*;
#(
   parameter int N_DIM_ARRAY       = w_mem_loader_pkg::N_DIM_ARRAY,
   parameter int WEIGHT_DATA_WIDTH = w_mem_loader_pkg::WEIGHT_DATA_WIDTH,
   parameter int ADDR_W            = WEIGHT_MEMORY_ADDR_SIZE,
   parameter int CNT_W             = CNT_WIDTH
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic                                  cfg_fc,
   input  logic [ADDR_W-1:0]                     cfg_base_addr,
   input  logic [CNT_W-1:0]                      cfg_num_words,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic signed [WEIGHT_DATA_WIDTH-1:0]   in_data,
   input  logic                                  stall,
   output logic                                  wr_enable_cnn,
   output logic [ADDR_W-1:0]                     wr_addr_cnn,
   output logic [N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0] wr_data_cnn,
   output logic                                  wr_enable_fc,
   output logic [ADDR_W-1:0]                     wr_addr_fc,
   output logic [N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0] wr_data_fc,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  addr_wrap
);

   localparam int WORD_W = N_DIM_ARRAY * WEIGHT_DATA_WIDTH;
   localparam int LANE_W = $clog2(N_DIM_ARRAY);
   localparam int BCNT_W = CNT_W + LANE_W;

   state_t             state_q;
   logic               fc_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [CNT_W-1:0]   words_left_q;
   logic [BCNT_W-1:0]  bytes_left_q;
   logic               busy_q;
   logic               done_q;
   logic               wrap_q;

   logic               last_lane;
   logic               word_load;
   logic               out_valid;
   logic               pk_fire;
   logic               wr_fire;
   logic               byte_fire;
   logic [WORD_W-1:0]  out_word;
   logic [ADDR_W-1:0]  out_addr;

   // Lane 3 may only be taken when the output register can be freed.
   assign in_ready  = (state_q == ST_LOAD) && (bytes_left_q != '0) &&
                      (!last_lane || !out_valid || !stall);
   assign byte_fire = in_valid && in_ready;
   // The pending word is discarded by reset, so it must not strobe then.
   assign wr_fire   = pk_fire && !reset;

   w_mem_byte_packer #(
      .LANES  (N_DIM_ARRAY),
      .BYTE_W (WEIGHT_DATA_WIDTH),
      .ADDR_W (ADDR_W)
   ) u_packer (
      .clk         (clk),
      .reset       (reset),
      .byte_fire_i (byte_fire),
      .byte_i      (in_data),
      .addr_i      (addr_q),
      .stall_i     (stall),
      .last_lane_o (last_lane),
      .word_load_o (word_load),
      .out_valid_o (out_valid),
      .wr_fire_o   (pk_fire),
      .out_word_o  (out_word),
      .out_addr_o  (out_addr)
   );

   assign wr_enable_cnn = wr_fire && (fc_q == MODE_CNN);
   assign wr_enable_fc  = wr_fire && (fc_q != MODE_CNN);
   assign wr_addr_cnn   = out_addr;
   assign wr_data_cnn   = out_word;
   assign wr_addr_fc    = out_addr;
   assign wr_data_fc    = out_word;
   assign busy          = busy_q;
   assign done          = done_q;
   assign addr_wrap     = wrap_q;

   // Transfer sequencing, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         fc_q         <= MODE_CNN;
         addr_q       <= '0;
         words_left_q <= '0;
         bytes_left_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         wrap_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (byte_fire) bytes_left_q <= bytes_left_q - 1'b1;
         if (wr_fire)   words_left_q <= words_left_q - 1'b1;
         if (word_load) begin
            addr_q <= addr_q + 1'b1;
            if (&addr_q) wrap_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  fc_q         <= cfg_fc;
                  addr_q       <= cfg_base_addr;
                  words_left_q <= cfg_num_words;
                  bytes_left_q <= BCNT_W'(cfg_num_words) << LANE_W;
                  wrap_q       <= 1'b0;
                  if (cfg_num_words == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_LOAD;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (byte_fire && bytes_left_q == BCNT_W'(1)) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (wr_fire && words_left_q == CNT_W'(1)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_w_mem_loader.sv
// Directed bench for w_mem_loader: write-port monitor plus hand-computed
// expectations for each transfer.
module tb_w_mem_loader;

   localparam int AW = 14;
   localparam int CW = 15;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              cfg_fc = 1'b0;
   logic [AW-1:0]     cfg_base_addr = '0;
   logic [CW-1:0]     cfg_num_words = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic signed [7:0] in_data = '0;
   logic              stall = 1'b0;
   logic              wr_enable_cnn, wr_enable_fc;
   logic [AW-1:0]     wr_addr_cnn, wr_addr_fc;
   logic [31:0]       wr_data_cnn, wr_data_fc;
   logic              busy, done, addr_wrap;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int acc_cyc  = 0;

   int          wq_port[$];
   int          wq_addr[$];
   logic [31:0] wq_data[$];
   int          wq_cyc[$];

   w_mem_loader dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .cfg_fc        (cfg_fc),
      .cfg_base_addr (cfg_base_addr),
      .cfg_num_words (cfg_num_words),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .stall         (stall),
      .wr_enable_cnn (wr_enable_cnn),
      .wr_addr_cnn   (wr_addr_cnn),
      .wr_data_cnn   (wr_data_cnn),
      .wr_enable_fc  (wr_enable_fc),
      .wr_addr_fc    (wr_addr_fc),
      .wr_data_fc    (wr_data_fc),
      .busy          (busy),
      .done          (done),
      .addr_wrap     (addr_wrap)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every write strobe and done pulse with the cycle it appeared in.
   always @(negedge clk) begin
      if (wr_enable_cnn) begin
         wq_port.push_back(0);
         wq_addr.push_back(int'(wr_addr_cnn));
         wq_data.push_back(wr_data_cnn);
         wq_cyc.push_back(cyc);
      end
      if (wr_enable_fc) begin
         wq_port.push_back(1);
         wq_addr.push_back(int'(wr_addr_fc));
         wq_data.push_back(wr_data_fc);
         wq_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wq_port.delete();
      wq_addr.delete();
      wq_data.delete();
      wq_cyc.delete();
   endtask

   task automatic do_start(input logic fc, input int base, input int nw, output int s);
      cfg_fc        = fc;
      cfg_base_addr = AW'(base);
      cfg_num_words = CW'(nw);
      start         = 1'b1;
      s             = cyc;
      step();
      start         = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int   guard;
      logic rdy;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = b;
      do begin
         #2;
         rdy     = in_ready;
         acc_cyc = cyc;
         @(posedge clk);
         #1;
         guard++;
      end while (!rdy && guard < 50);
      in_valid = 1'b0;
      if (!rdy) check("byte_timeout", 0, 1);
   endtask

   task automatic send_seq(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) send_byte(first + 8'(i));
   endtask

   task automatic wait_done(input int prev);
      int g;
      g = 0;
      while (done_cnt == prev && g < 100) begin
         step();
         g++;
      end
      check("done_seen", done_cnt, prev + 1);
      step();
      step();
   endtask

   initial begin
      int s, d0, a4, nw;

      repeat (3) step();
      reset = 1'b0;
      #2;
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wrap", addr_wrap, 0);
      check("rst_en_cnn", wr_enable_cnn, 0);
      check("rst_en_fc", wr_enable_fc, 0);
      check("rst_addr", wr_addr_cnn, 0);
      check("rst_data", wr_data_cnn, 0);
      step();

      // CNN transfer, 2 words from 0x0010
      clear_log();
      d0 = done_cnt;
      do_start(1'b0, 'h0010, 2, s);
      check("t1_busy", busy, 1);
      send_seq(8'h01, 4);
      a4 = acc_cyc;
      send_seq(8'h05, 4);
      wait_done(d0);
      check("t1_nwr", wq_port.size(), 2);
      check("t1_port0", wq_port[0], 0);
      check("t1_addr0", wq_addr[0], 'h10);
      check("t1_data0", wq_data[0], 32'h01020304);
      check("t1_port1", wq_port[1], 0);
      check("t1_addr1", wq_addr[1], 'h11);
      check("t1_data1", wq_data[1], 32'h05060708);
      check("t1_latency", wq_cyc[0], a4 + 1);
      check("t1_done_cyc", done_cyc, wq_cyc[1] + 1);
      check("t1_done_once", done_cnt, d0 + 1);
      check("t1_busy_end", busy, 0);
      check("t1_wrap", addr_wrap, 0);

      // FC transfer with a stray start mid-transfer that must be ignored
      clear_log();
      d0 = done_cnt;
      do_start(1'b1, 'h0010, 2, s);
      send_seq(8'h01, 2);
      do_start(1'b0, 'h0100, 0, s);
      send_seq(8'h03, 6);
      wait_done(d0);
      check("t2_nwr", wq_port.size(), 2);
      check("t2_port0", wq_port[0], 1);
      check("t2_addr0", wq_addr[0], 'h10);
      check("t2_data0", wq_data[0], 32'h01020304);
      check("t2_port1", wq_port[1], 1);
      check("t2_addr1", wq_addr[1], 'h11);
      check("t2_data1", wq_data[1], 32'h05060708);
      check("t2_done_once", done_cnt, d0 + 1);

      // Stall holds the first word while lane 3 of the second is pending
      clear_log();
      d0 = done_cnt;
      stall = 1'b1;
      do_start(1'b0, 'h0020, 2, s);
      send_seq(8'h81, 7);
      in_valid = 1'b1;
      in_data  = 8'h88;
      for (int k = 0; k < 5; k++) begin
         #2;
         check("t3_ready_low", in_ready, 0);
         @(posedge clk);
         #1;
      end
      check("t3_no_wr_stalled", wq_port.size(), 0);
      stall = 1'b0;
      send_byte(8'h88);
      wait_done(d0);
      check("t3_nwr", wq_port.size(), 2);
      check("t3_addr0", wq_addr[0], 'h20);
      check("t3_data0", wq_data[0], 32'h81828384);
      check("t3_addr1", wq_addr[1], 'h21);
      check("t3_data1", wq_data[1], 32'h85868788);
      check("t3_b2b", wq_cyc[1], wq_cyc[0] + 1);

      // Address wrap from the top of the memory
      clear_log();
      d0 = done_cnt;
      do_start(1'b0, 'h3FFF, 2, s);
      send_seq(8'h11, 8);
      wait_done(d0);
      check("t4_nwr", wq_port.size(), 2);
      check("t4_addr0", wq_addr[0], 'h3FFF);
      check("t4_data0", wq_data[0], 32'h11121314);
      check("t4_addr1", wq_addr[1], 'h0000);
      check("t4_data1", wq_data[1], 32'h15161718);
      check("t4_wrap", addr_wrap, 1);
      step();
      step();
      check("t4_wrap_sticky", addr_wrap, 1);

      // Zero-word transfer: done straight away, clears wrap, no writes
      clear_log();
      d0 = done_cnt;
      do_start(1'b0, 'h0100, 0, s);
      step();
      step();
      check("t5_done_cnt", done_cnt, d0 + 1);
      check("t5_done_cyc", done_cyc, s + 1);
      check("t5_nwr", wq_port.size(), 0);
      check("t5_wrap_clr", addr_wrap, 0);
      check("t5_busy", busy, 0);
      step();

      // Reset after 6 of 8 bytes with the first word still pending
      clear_log();
      stall = 1'b1;
      do_start(1'b0, 'h0040, 2, s);
      send_seq(8'h21, 6);
      reset = 1'b1;
      stall = 1'b0;
      step();
      reset = 1'b0;
      #2;
      check("t6_no_wr_in_reset", wq_port.size(), 0);
      check("t6_en_cnn", wr_enable_cnn, 0);
      check("t6_addr", wr_addr_cnn, 0);
      check("t6_data", wr_data_cnn, 0);
      check("t6_ready", in_ready, 0);
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      step();
      d0 = done_cnt;
      do_start(1'b0, 'h0050, 1, s);
      send_seq(8'hA1, 4);
      wait_done(d0);
      nw = wq_port.size();
      check("t6_nwr", nw, 1);
      check("t6_port", wq_port[0], 0);
      check("t6_addr0", wq_addr[0], 'h50);
      check("t6_data0", wq_data[0], 32'hA1A2A3A4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
